// File: rtl/code_loader.sv
// Loader for the instruction ROM: assembles a framed byte stream (magic, length, words, XOR checksum)
// into 32-bit little-endian ROM writes while holding the CPU in reset.
module code_loader #(
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      loadEn,
  input  logic [7:0]                rxData,
  input  logic                      rxValid,
  output logic                      rxReady,
  output logic [MEM_ADDR_WIDTH-1:0] addrIn,
  output logic [31:0]               dataIn,
  output logic [3:0]                sizeDecode,
  output logic                      cpuHold,
  output logic                      done,
  output logic                      error
);

  typedef enum logic [3:0] {
    S_IDLE, S_MAGIC, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] CAPACITY = 17'd1 << MEM_ADDR_WIDTH;

  state_t                    state, state_next;
  logic [15:0]               len;
  logic [16:0]               word_cnt;
  logic [1:0]                byte_cnt;
  logic [23:0]               word_buf;
  logic [7:0]                csum;
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               data_q;
  logic                      start;
  logic                      accept;
  logic [16:0]               len_full;
  logic [16:0]               word_cnt_inc;

  assign accept       = rxValid && rxReady;
  assign len_full     = {1'b0, rxData, len[7:0]};
  assign word_cnt_inc = word_cnt + 17'd1;
  assign addrIn       = addr_q;
  assign dataIn       = data_q;
  assign done         = (state == S_DONE);
  assign error        = (state == S_ERR);
  // CPU runs only when idle after reset or after a verified load.
  assign cpuHold      = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    state_next = state;
    rxReady    = 1'b0;
    sizeDecode = 4'b0000;
    start      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (loadEn) begin
          start      = 1'b1;
          state_next = S_MAGIC;
        end
      end
      S_MAGIC: begin
        rxReady = 1'b1;
        if (rxValid) state_next = (rxData == 8'hA5) ? S_LEN0 : S_ERR;
      end
      S_LEN0: begin
        rxReady = 1'b1;
        if (rxValid) state_next = S_LEN1;
      end
      S_LEN1: begin
        rxReady = 1'b1;
        if (rxValid) begin
          if (len_full == 17'd0)         state_next = S_CHECK;
          else if (len_full > CAPACITY)  state_next = S_ERR;
          else                           state_next = S_DATA;
        end
      end
      S_DATA: begin
        rxReady = 1'b1;
        if (rxValid && byte_cnt == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        sizeDecode = 4'b1111;
        state_next = (word_cnt_inc == {1'b0, len}) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        rxReady = 1'b1;
        if (rxValid) state_next = (rxData == csum) ? S_DONE : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      len      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      word_buf <= '0;
      csum     <= '0;
      addr     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        len      <= '0;
        word_cnt <= '0;
        byte_cnt <= '0;
        csum     <= '0;
        addr     <= '0;
      end
      if (accept) begin
        case (state)
          S_LEN0: len[7:0]  <= rxData;
          S_LEN1: len[15:8] <= rxData;
          S_DATA: begin
            csum     <= csum ^ rxData;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= rxData;
              2'd1: word_buf[15:8]  <= rxData;
              2'd2: word_buf[23:16] <= rxData;
              default: begin
                // Present the finished word during the WRITE cycle and hold it afterwards.
                data_q <= {rxData, word_buf};
                addr_q <= addr;
              end
            endcase
          end
          default: ;
        endcase
      end
      if (state == S_WRITE) begin
        addr     <= addr + 1'b1;
        word_cnt <= word_cnt_inc;
        byte_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: table of frames plus hand-written multi-cycle corner cases.
module tb_code_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, loadEn, rxValid, rxReady;
  logic [7:0]    rxData;
  logic [AW-1:0] addrIn;
  logic [31:0]   dataIn;
  logic [3:0]    sizeDecode;
  logic          cpuHold, done, error;

  code_loader #(.MEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .loadEn(loadEn), .rxData(rxData), .rxValid(rxValid),
    .rxReady(rxReady), .addrIn(addrIn), .dataIn(dataIn), .sizeDecode(sizeDecode),
    .cpuHold(cpuHold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Write monitor: every strobe cycle is logged; a malformed strobe or rxReady during a write is flagged.
  logic [AW-1:0] wr_addr [64];
  logic [31:0]   wr_data [64];
  int wr_n    = 0;
  int rdy_bad = 0;
  always @(negedge clk) begin
    if (sizeDecode != 4'h0) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = addrIn;
        wr_data[wr_n] = dataIn;
      end
      wr_n++;
      if (sizeDecode != 4'hF || rxReady) rdy_bad++;
    end
  end

  typedef struct {
    string        name;
    int           nb;
    logic [127:0] bytes;
    bit           thr;
    int           nwr;
    logic [31:0]  d0;
    logic [31:0]  d1;
    bit           exp_done;
    bit           exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit thr);
    int budget;
    if (thr) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    rxValid = 1'b1;
    rxData  = b;
    budget  = 0;
    while (!rxReady && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (!rxReady) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: rxReady stayed %b for byte %h, required 1", rxReady, b);
      rxValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rxValid = 1'b0;
  endtask

  task automatic pulse_load();
    @(negedge clk);
    loadEn = 1'b1;
    @(posedge clk);
    #1;
    loadEn = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int base, rdy0;
    logic [7:0] b;
    base = wr_n;
    rdy0 = rdy_bad;
    pulse_load();
    chk({v.name, "_hold_start"}, cpuHold, 1);
    for (int i = 0; i < v.nb; i++) begin
      b = v.bytes[127 - i*8 -: 8];
      send_byte(b, v.thr);
      if (i >= 3 && i < 3 + 4*v.nwr && (i - 3) % 4 == 3) begin
        chk({v.name, "_strobe"}, sizeDecode, 4'hF);
        chk({v.name, "_strobe_addr"}, addrIn, (i - 3) / 4);
      end
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    chk({v.name, "_nwrites"}, wr_n - base, v.nwr);
    if (v.nwr > 0) begin
      chk({v.name, "_w0_addr"}, wr_addr[base], 0);
      chk({v.name, "_w0_data"}, wr_data[base], v.d0);
    end
    if (v.nwr > 1) begin
      chk({v.name, "_w1_addr"}, wr_addr[base+1], 1);
      chk({v.name, "_w1_data"}, wr_data[base+1], v.d1);
    end
    chk({v.name, "_done"}, done, v.exp_done);
    chk({v.name, "_error"}, error, v.exp_err);
    chk({v.name, "_cpuhold"}, cpuHold, v.exp_err);
    chk({v.name, "_rxready"}, rxReady, 0);
    chk({v.name, "_write_rdy"}, rdy_bad - rdy0, 0);
  endtask

  function automatic logic [127:0] lj(input logic [127:0] x, input int n);
    return x << (128 - 8*n);
  endfunction

  initial begin
    logic [7:0] b, cs;
    int base;

    vecs[0] = '{"good",      12, lj(128'hA5020011223344556677_8888, 12), 0, 2, 32'h44332211, 32'h88776655, 1, 0};
    vecs[1] = '{"bad_magic",  1, lj(128'h5A, 1),                          0, 0, 32'h0, 32'h0, 0, 1};
    vecs[2] = '{"bad_csum",  12, lj(128'hA5020011223344556677_8800, 12), 0, 2, 32'h44332211, 32'h88776655, 0, 1};
    vecs[3] = '{"oversize",   3, lj(128'hA51100, 3),                      0, 0, 32'h0, 32'h0, 0, 1};
    vecs[4] = '{"empty",      4, lj(128'hA5000000, 4),                    0, 0, 32'h0, 32'h0, 1, 0};
    vecs[5] = '{"empty_bad",  4, lj(128'hA5000001, 4),                    0, 0, 32'h0, 32'h0, 0, 1};
    vecs[6] = '{"throttled", 12, lj(128'hA5020011223344556677_8888, 12), 1, 2, 32'h44332211, 32'h88776655, 1, 0};

    rst = 1'b1; loadEn = 1'b0; rxValid = 1'b0; rxData = 8'h00;
    #12;
    chk("rst_rxready", rxReady, 0);
    chk("rst_addr", addrIn, 0);
    chk("rst_data", dataIn, 0);
    chk("rst_size", sizeDecode, 0);
    chk("rst_hold", cpuHold, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    rst = 1'b0;

    // loadEn together with a valid 0xA5 in IDLE: the byte must not be consumed.
    @(negedge clk);
    loadEn = 1'b1; rxValid = 1'b1; rxData = 8'hA5;
    @(posedge clk);
    #1;
    loadEn = 1'b0; rxValid = 1'b0;
    chk("idle_sim_hold", cpuHold, 1);
    chk("idle_sim_ready", rxReady, 1);
    send_byte(8'h5A, 0);
    chk("idle_sim_err", error, 1);

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Full-capacity frame: 16 words into a 16-word ROM.
    base = wr_n;
    cs = 8'h00;
    pulse_load();
    send_byte(8'hA5, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    for (int w = 0; w < 16; w++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'(w*16 + j);
        cs = cs ^ b;
        send_byte(b, 0);
      end
      if (w == 0 || w == 15) chk("full_strobe_addr", addrIn, w);
    end
    send_byte(cs, 0);
    @(negedge clk);
    #1;
    chk("full_done", done, 1);
    chk("full_nwrites", wr_n - base, 16);
    chk("full_last_addr", wr_addr[base+15], 4'hF);
    chk("full_last_data", wr_data[base+15], 32'hF3F2F1F0);

    // loadEn mid-DATA must be ignored.
    base = wr_n;
    pulse_load();
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    pulse_load();
    send_byte(8'h33, 0); send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
    send_byte(8'h77, 0); send_byte(8'h88, 0); send_byte(8'h88, 0);
    @(negedge clk);
    #1;
    chk("ign_done", done, 1);
    chk("ign_nwrites", wr_n - base, 2);
    chk("ign_w1_data", wr_data[base+1], 32'h88776655);

    // Reset after 6 data bytes, then a clean reload.
    pulse_load();
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_hold", cpuHold, 0);
    chk("mid_rst_ready", rxReady, 0);
    chk("mid_rst_addr", addrIn, 0);
    chk("mid_rst_data", dataIn, 0);
    chk("mid_rst_size", sizeDecode, 0);
    chk("mid_rst_flags", {done, error}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
